// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: out_d = in_x - in_y, LSB first, one bit per clock.
// Optional macro SERIAL_SUBTRACTOR_ADDSUB_EN adds port in_sub (1 = subtract, 0 = add).
module serial_subtractor #(
  parameter int n = 4
) (
  input  logic         in_clk,
  input  logic         in_rst,
  input  logic         in_start,
`ifdef SERIAL_SUBTRACTOR_ADDSUB_EN
  input  logic         in_sub,
`endif
  input  logic [n-1:0] in_x,
  input  logic [n-1:0] in_y,
  output logic         out_busy,
  output logic         out_done,
  output logic [n-1:0] out_d,
  output logic         out_b,
  output logic         out_overflow
);

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_next;

  logic [n-1:0]  x_sr, y_sr;
  logic [n-2:0]  d_sr;
  logic          x_msb, y_msb;
  logic          borrow;
  logic [CW-1:0] count;

  logic          accept, last_bit, sub_mode;
  logic          xi, yi, di, b_next, ov;
  logic [n-1:0]  d_full;

`ifdef SERIAL_SUBTRACTOR_ADDSUB_EN
  logic sub_q;

  always_ff @(posedge in_clk) begin
    if (in_rst)      sub_q <= 1'b1;
    else if (accept) sub_q <= in_sub;
  end

  assign sub_mode = sub_q;
`else
  assign sub_mode = 1'b1;
`endif

  always_ff @(posedge in_clk) begin
    if (in_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        accept = in_start;
        if (in_start) state_next = SHIFT;
      end
      SHIFT: begin
        last_bit = (count == LAST);
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        accept     = in_start;
        state_next = in_start ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One full-subtractor (or full-adder) slice; the carry/borrow register is shared.
  always_comb begin
    xi     = x_sr[0];
    yi     = y_sr[0];
    di     = xi ^ yi ^ borrow;
    b_next = sub_mode ? ((~xi & yi) | (~(xi ^ yi) & borrow))
                      : ((xi & yi) | ((xi ^ yi) & borrow));
    d_full = {di, d_sr};
    ov     = sub_mode ? ((x_msb ^ y_msb) & (di ^ x_msb))
                      : (~(x_msb ^ y_msb) & (di ^ x_msb));
  end

  // Result outputs only move on the edge that enters DONE, so they hold across later operations.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      x_sr         <= '0;
      y_sr         <= '0;
      d_sr         <= '0;
      x_msb        <= 1'b0;
      y_msb        <= 1'b0;
      borrow       <= 1'b0;
      count        <= '0;
      out_d        <= '0;
      out_b        <= 1'b0;
      out_overflow <= 1'b0;
    end else if (accept) begin
      x_sr   <= in_x;
      y_sr   <= in_y;
      d_sr   <= '0;
      x_msb  <= in_x[n-1];
      y_msb  <= in_y[n-1];
      borrow <= 1'b0;
      count  <= '0;
    end else if (state == SHIFT) begin
      x_sr   <= x_sr >> 1;
      y_sr   <= y_sr >> 1;
      d_sr   <= d_full[n-1:1];
      borrow <= b_next;
      count  <= count + CW'(1);
      if (last_bit) begin
        out_d        <= d_full;
        out_b        <= b_next;
        out_overflow <= ov;
      end
    end
  end

  assign out_busy = (state == SHIFT);
  assign out_done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (n=4); expected results come from an arithmetic model.
module tb_serial_subtractor;

  typedef struct packed {
    logic [3:0] d;
    logic       b;
    logic       ov;
  } exp_t;

  logic       in_clk = 1'b0;
  logic       in_rst, in_start;
  logic [3:0] in_x, in_y;
  logic       out_busy, out_done, out_b, out_overflow;
  logic [3:0] out_d;
`ifdef SERIAL_SUBTRACTOR_ADDSUB_EN
  logic       in_sub = 1'b1;
`endif

  int   compared = 0;
  int   mismatched = 0;
  int   done_count = 0;
  int   cycle = 0;
  int   last_done_cycle = 0;
  int   prev_done_cycle = 0;
  logic sub_mode = 1'b1;
  exp_t exp_q[$];

  serial_subtractor #(.n(4)) dut (
    .in_clk      (in_clk),
    .in_rst      (in_rst),
    .in_start    (in_start),
`ifdef SERIAL_SUBTRACTOR_ADDSUB_EN
    .in_sub      (in_sub),
`endif
    .in_x        (in_x),
    .in_y        (in_y),
    .out_busy    (out_busy),
    .out_done    (out_done),
    .out_d       (out_d),
    .out_b       (out_b),
    .out_overflow(out_overflow)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) cycle++;

  // Reference: plain wide arithmetic, independent of the serial bit loop.
  function automatic exp_t model(input logic [3:0] x, input logic [3:0] y, input logic sub);
    exp_t       e;
    logic [4:0] r;
    if (sub) begin
      r    = {1'b0, x} - {1'b0, y};
      e.d  = r[3:0];
      e.b  = (x < y);
      e.ov = (x[3] ^ y[3]) & (e.d[3] ^ x[3]);
    end else begin
      r    = {1'b0, x} + {1'b0, y};
      e.d  = r[3:0];
      e.b  = r[4];
      e.ov = ~(x[3] ^ y[3]) & (e.d[3] ^ x[3]);
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Drives a start for one cycle; the accepting edge is the one this task waits on.
  task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y, input bit push);
    in_x     = x;
    in_y     = y;
    in_start = 1'b1;
    if (push) exp_q.push_back(model(x, y, sub_mode));
    @(posedge in_clk);
    #1 in_start = 1'b0;
  endtask

  task automatic runOp(input logic [3:0] x, input logic [3:0] y);
    applyStimulus(x, y, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge in_clk);
      checkOutput($sformatf("busy_c%0d", i), out_busy, 1'b1);
      checkOutput($sformatf("nodone_c%0d", i), out_done, 1'b0);
    end
    @(negedge in_clk);
    checkOutput("done_pulse", out_done, 1'b1);
    checkOutput("busy_low", out_busy, 1'b0);
    @(posedge in_clk);
    #1;
  endtask

  task automatic waitDones(input int target, input int budget);
    int n_cyc;
    n_cyc = 0;
    while (done_count < target && n_cyc < budget) begin
      @(posedge in_clk);
      n_cyc++;
    end
    #1;
    if (done_count < target) checkOutput("done_timeout", done_count, target);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest outstanding expectation.
  always @(negedge in_clk) begin
    if (!in_rst && out_done) begin
      done_count++;
      prev_done_cycle = last_done_cycle;
      last_done_cycle = cycle;
      if (exp_q.size() == 0) begin
        checkOutput("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("out_d", out_d, e.d);
        checkOutput("out_b", out_b, e.b);
        checkOutput("out_overflow", out_overflow, e.ov);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    in_rst   = 1'b1;
    in_start = 1'b0;
    in_x     = '0;
    in_y     = '0;
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    checkOutput("rst_busy", out_busy, 1'b0);
    checkOutput("rst_done", out_done, 1'b0);
    checkOutput("rst_d", out_d, 4'h0);
    checkOutput("rst_b", out_b, 1'b0);
    checkOutput("rst_ov", out_overflow, 1'b0);
    in_rst = 1'b0;
    @(posedge in_clk);
    #1;

    runOp(4'h7, 4'h3);
    runOp(4'h3, 4'h5);
    for (int i = 0; i < 3; i++) begin
      @(negedge in_clk);
      checkOutput($sformatf("hold_d_%0d", i), out_d, 4'hE);
      checkOutput($sformatf("hold_nodone_%0d", i), out_done, 1'b0);
    end
    @(posedge in_clk);
    #1;
    runOp(4'h8, 4'h1);
    runOp(4'h7, 4'hF);
    for (int i = 0; i < 4; i++) runOp(4'($urandom_range(15)), 4'($urandom_range(15)));

    // A start pulse during SHIFT with new operands must be ignored.
    base = done_count;
    applyStimulus(4'h9, 4'h2, 1'b1);
    in_x     = 4'h0;
    in_y     = 4'h0;
    in_start = 1'b1;
    @(posedge in_clk);
    #1 in_start = 1'b0;
    waitDones(base + 1, 20);
    repeat (6) @(posedge in_clk);
    #1;
    checkOutput("single_done", done_count - base, 1);

    // Back-to-back: start held high across the DONE cycle.
    base     = done_count;
    in_x     = 4'hA;
    in_y     = 4'hA;
    in_start = 1'b1;
    exp_q.push_back(model(4'hA, 4'hA, sub_mode));
    @(posedge in_clk);
    #1;
    in_x = 4'h0;
    in_y = 4'h1;
    exp_q.push_back(model(4'h0, 4'h1, sub_mode));
    repeat (5) @(posedge in_clk);
    #1 in_start = 1'b0;
    waitDones(base + 2, 30);
    checkOutput("b2b_spacing", last_done_cycle - prev_done_cycle, 5);

    // Reset on the second SHIFT cycle aborts the operation.
    base = done_count;
    applyStimulus(4'h5, 4'h1, 1'b0);
    @(posedge in_clk);
    #1 in_rst = 1'b1;
    @(posedge in_clk);
    #1 in_rst = 1'b0;
    @(negedge in_clk);
    checkOutput("abort_busy", out_busy, 1'b0);
    checkOutput("abort_done", out_done, 1'b0);
    checkOutput("abort_d", out_d, 4'h0);
    checkOutput("abort_b", out_b, 1'b0);
    checkOutput("abort_ov", out_overflow, 1'b0);
    repeat (8) @(posedge in_clk);
    #1;
    checkOutput("abort_no_done", done_count - base, 0);
    runOp(4'h2, 4'h6);

`ifdef SERIAL_SUBTRACTOR_ADDSUB_EN
    sub_mode = 1'b0;
    in_sub   = 1'b0;
    runOp(4'h7, 4'h1);
    runOp(4'hF, 4'h1);
    sub_mode = 1'b1;
    in_sub   = 1'b1;
    runOp(4'h1, 4'h2);
`endif

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Iterative bit-serial two's-complement subtractor; computes out_d = in_x - in_y, one bit per clock, LSB first.
- Reports borrow and signed overflow for use by the arithmetic datapath.
- Start/done handshake; results held stable until the next accepted start.

Parameters:
- n, 4, operand and result width in bits (n >= 2).

Ports:
- in_clk  input  1  clock; all state updates on rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_start  input  1  request; accepted only in IDLE or DONE.
- in_x  input  n  minuend; sampled on the accepting edge only.
- in_y  input  n  subtrahend; sampled on the accepting edge only.
- out_busy  output  1  high while in SHIFT.
- out_done  output  1  one-cycle pulse; results valid.
- out_d  output  n  difference, (in_x - in_y) mod 2^n.
- out_b  output  1  borrow; 1 iff in_x < in_y unsigned.
- out_overflow  output  1  signed overflow of the subtraction.

Behaviour:
- Reset (in_rst=1 at a rising edge): state=IDLE; out_busy=0, out_done=0, out_d=0, out_b=0, out_overflow=0; internal shift registers, bit counter and borrow cleared. Reset wins over every other input. Reset during SHIFT aborts the operation; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE: in_start=1 -> latch in_x/in_y into shift regs, borrow=0, count=0, go to SHIFT. in_start=0 -> stay.
- SHIFT, one bit i per edge: d_i = x_i ^ y_i ^ b; b_next = (~x_i & y_i) | (~(x_i ^ y_i) & b). Shift d_i into the result register from the MSB side. Increment count. After bit n-1 is processed, go to DONE.
- In SHIFT, in_start is ignored and in_x/in_y changes have no effect.
- On entry to DONE, update outputs:
  - out_d = assembled result.
  - out_b = final borrow.
  - out_overflow = (x[n-1] ^ y[n-1]) & (d[n-1] ^ x[n-1]), using the latched operands.
- Outputs out_d, out_b and out_overflow change only on entry to DONE (or reset). They hold through IDLE and the next SHIFT.
- DONE lasts exactly one cycle with out_done=1. Next state is SHIFT if in_start=1 (back-to-back accept, new operands latched), otherwise IDLE.
- Latency: start accepted at edge E; out_busy=1 from E to E+n; out_done=1 in the cycle after edge E+n.
- Back-to-back throughput: one result every n+1 cycles.
- Counter width: clog2(n+1). No wrap-around is possible; the counter is reset on every accept.

Optional Feature:
- Macro SERIAL_SUBTRACTOR_ADDSUB_EN.
- Defined:
  - Extra input port in_sub (1 bit), sampled with the operands.
  - in_sub=1: behaviour exactly as above.
  - in_sub=0: addition. Per-bit carry c_next = (x_i & y_i) | ((x_i ^ y_i) & c), initial c=0. out_b carries the carry-out.
  - Addition overflow: out_overflow = ~(x[n-1] ^ y[n-1]) & (d[n-1] ^ x[n-1]).
- Undefined: port in_sub absent; subtraction only.

Test Plan (n=4):
- Reset then x=7, y=3, start -> out_busy high 4 cycles, then out_done pulse with out_d=4'h4, out_b=0, out_overflow=0.
- x=3, y=5 -> out_d=4'hE, out_b=1, out_overflow=0; out_d holds 4'hE through 3 idle cycles.
- x=8 (-8), y=1 -> out_d=4'h7, out_b=0, out_overflow=1. Then x=7, y=F (-1) -> out_d=4'h8, out_b=1, out_overflow=1.
- Start x=9, y=2; in the SHIFT cycle after accept, pulse start with x=0, y=0 -> ignored; result 4'h7, exactly one done pulse.
- Back-to-back: hold in_start high (x=A, y=A, then x=0, y=1) -> done pulses 5 cycles apart; results 4'h0/b=0, then 4'hF/b=1.
- Assert in_rst on the 2nd SHIFT cycle -> next cycle all outputs 0, state IDLE, no done. With ADDSUB_EN: in_sub=0, x=7, y=1 -> out_d=4'h8, out_b=0, out_overflow=1.
